// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the control unit and the multiply/divide unit.
// The control unit drives the master side; the muldiv unit drives the slave side.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opa, opb,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide, one bit per clock, on magnitudes with signs applied at writeback.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [2:0] OpMultu = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpDivu  = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, div_by_zero_q;

  // acc_q: running product high half / partial remainder.
  // qr_q: multiplier being shifted out / dividend shifted out, quotient shifted in.
  logic [WIDTH-1:0] acc_q, qr_q, mcand_q;
  logic             is_div_q, neg_q, neg_rem_q;

  logic             op_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] acc_n, qr_n;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign op_signed = bus.op[0];

  always_comb begin
    mag_a = (op_signed && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    mag_b = (op_signed && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

    mul_sum   = qr_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
    div_shift = {acc_q, qr_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};

    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_n = div_diff[WIDTH-1:0];
        qr_n  = {qr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = div_shift[WIDTH-1:0];
        qr_n  = {qr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = mul_sum[WIDTH:1];
      qr_n  = {mul_sum[0], qr_q[WIDTH-1:1]};
    end

    prod     = {acc_n, qr_n};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -qr_n : qr_n;
    rem_fix  = neg_rem_q ? -acc_n : acc_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      count_q       <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      acc_q         <= '0;
      qr_q          <= '0;
      mcand_q       <= '0;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      neg_rem_q     <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            case (bus.op)
              OpMultu, OpMult: begin
                state_q   <= StCalc;
                busy_q    <= 1'b1;
                count_q   <= '0;
                acc_q     <= '0;
                qr_q      <= mag_b;
                mcand_q   <= mag_a;
                is_div_q  <= 1'b0;
                neg_q     <= op_signed && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                neg_rem_q <= 1'b0;
              end
              OpDivu, OpDiv: begin
                if (bus.opb == '0) begin
                  // Zero divisor: skip CALC, leave HI/LO untouched.
                  state_q       <= StDone;
                  done_q        <= 1'b1;
                  div_by_zero_q <= 1'b1;
                end else begin
                  state_q   <= StCalc;
                  busy_q    <= 1'b1;
                  count_q   <= '0;
                  acc_q     <= '0;
                  qr_q      <= mag_a;
                  mcand_q   <= mag_b;
                  is_div_q  <= 1'b1;
                  neg_q     <= op_signed && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                  neg_rem_q <= op_signed && bus.opa[WIDTH-1];
                end
              end
              OpMthi:  hi_q <= bus.opa;
              OpMtlo:  lo_q <= bus.opa;
              default: ;
            endcase
          end
        end
        StCalc: begin
          acc_q <= acc_n;
          qr_q  <= qr_n;
          if (count_q == CntLast) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO/div_by_zero queued at issue time and
// popped when done pulses; latency, busy length, MTHI/MTLO, ignored starts and reset.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  localparam logic [2:0] MULTU = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] DIVU  = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;
  localparam logic [2:0] NOP   = 3'b110;

  typedef struct {
    string          tag;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle, then scramble operands to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.opa   = $urandom;
    bus.opb   = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edbz, input int exp_lat, input bit poke);
    exp_t e;
    exp_t got;
    int   lat;
    int   busy_n;
    e.tag = tag;
    e.hi  = eh;
    e.lo  = el;
    e.dbz = edbz;
    sb.push_back(e);
    issue(op, a, b);
    lat    = 1;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat <= int'(W) + 4) begin
      if (bus.busy === 1'b1) busy_n++;
      if (poke && lat < 10) begin
        bus.start = 1'b1;
        bus.op    = MULTU;
        bus.opa   = 32'd9;
        bus.opb   = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    if (bus.done === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      chk({got.tag, "_hi"}, 64'(bus.hi), 64'(got.hi));
      chk({got.tag, "_lo"}, 64'(bus.lo), 64'(got.lo));
      chk({got.tag, "_dbz"}, 64'(bus.div_by_zero), 64'(got.dbz));
    end
    @(negedge clk);
    chk({tag, "_done_cleared"}, 64'(bus.done), 64'd0);
    chk({tag, "_dbz_cleared"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = NOP;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);

    // Unsigned and signed arithmetic.
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, W + 1, 1'b0);
    run_op("mult_m3x7", MULT, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, W + 1, 1'b0);
    run_op("div_m7d2", DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 1, 1'b0);
    run_op("div_7dm2", DIV, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD, 1'b0, W + 1, 1'b0);
    run_op("divu_100d7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W + 1, 1'b0);
    run_op("div_by_zero", DIV, 32'd5, 32'd0, 32'd2, 32'd14, 1'b1, 1, 1'b0);

    // Most-negative operand corners.
    run_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 1'b0, W + 1, 1'b0);
    run_op("mult_min_min", MULT, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'd0, 1'b0, W + 1, 1'b0);

    // Back-to-back MTHI/MTLO, then a NOP that must change nothing.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MTHI;
    bus.opa   = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);
    bus.op  = MTLO;
    bus.opa = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
    chk("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    chk("mtlo_done", 64'(bus.done), 64'd0);
    bus.op  = NOP;
    bus.opa = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    chk("nop_hi", 64'(bus.hi), 64'h1234_5678);
    chk("nop_lo", 64'(bus.lo), 64'h9ABC_DEF0);
    chk("nop_busy", 64'(bus.busy), 64'd0);

    // Starts raised during CALC must be dropped.
    run_op("multu_ignore_start", MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, W + 1, 1'b1);

    // Reset in the middle of a DIVU: no done, HI/LO cleared.
    issue(DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    for (int i = 0; i < int'(W) + 4; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        chk("midrst_quiet", 64'({bus.done, bus.busy}), 64'd0);
      end
    end
    chk("midrst_hi_after", 64'(bus.hi), 64'd0);
    run_op("multu_6x7", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, W + 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
